// File: rtl/cache_bus_sram_slave_if.sv
//------------------------------------------------------------------------------
// Module      : cache_bus_sram_slave_if
// Description : Cache bus bundle. The request travels from master to slave,
//               the response from slave to master.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface cache_bus_sram_slave_if;

  typedef struct packed {
    logic        valid;
    logic        write;
    logic [3:0]  burst_size;   // beats - 1
    logic [1:0]  data_size;
    logic [31:0] addr;
    logic        cached;
    logic        data_ok;      // read data accept / write beat valid
    logic        data_last;
    logic [3:0]  data_strobe;
    logic [31:0] w_data;
  } cache_bus_req_t;

  typedef struct packed {
    logic        ready;        // address accept
    logic        data_ok;      // read beat valid / write beat consumed
    logic        data_last;
    logic [31:0] r_data;
  } cache_bus_resp_t;

  cache_bus_req_t  req;
  cache_bus_resp_t resp;

  modport master (output req, input resp);
  modport slave  (input req, output resp);

endinterface

`default_nettype wire

// File: rtl/cache_bus_sram_slave.sv
//------------------------------------------------------------------------------
// Module      : cache_bus_sram_slave
// Description : Cache bus responder backed by a single-port synchronous SRAM.
//               Serves one burst at a time at one beat per cycle; linear
//               addressing that wraps modulo MEM_WORDS.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module cache_bus_sram_slave #(
  parameter int MEM_WORDS = 4096,
  parameter int MAX_BURST = 16
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  cache_bus_sram_slave_if.slave  bus
);

  localparam int IDX = $clog2(MEM_WORDS);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_RDATA = 2'd1;
  localparam logic [1:0] c_WDATA = 2'd2;

  localparam logic [3:0] c_BEATS_MAX_M1 = 4'(MAX_BURST - 1);

  logic [1:0]     r_state;
  logic [IDX-1:0] r_ptr;
  logic [3:0]     r_beats;
  logic           r_out_valid;
  logic [31:0]    r_rdata;
  logic [31:0]    r_mem [MEM_WORDS];

  logic           w_accept;
  logic           w_ready;
  logic           w_resp_ok;
  logic           w_last_beat;
  logic           w_rd_xfer;
  logic           w_wr_beat;
  logic           w_mem_re;
  logic [IDX-1:0] w_ptr_next;
  logic [IDX-1:0] w_mem_raddr;
  logic [3:0]     w_burst;
  logic           w_unused_ok;

  // Handshake and beat qualification; everything is masked while in reset
  // so no beat can be consumed (or written) during rst_n low.
  always_comb begin
    w_ready     = rst_n && (r_state == c_IDLE);
    w_accept    = w_ready && bus.req.valid;
    w_resp_ok   = rst_n && (((r_state == c_RDATA) && r_out_valid) ||
                            ((r_state == c_WDATA) && bus.req.data_ok));
    w_last_beat = (r_beats == 4'd0);
    w_rd_xfer   = (r_state == c_RDATA) && w_resp_ok && bus.req.data_ok;
    w_wr_beat   = (r_state == c_WDATA) && w_resp_ok;
    w_ptr_next  = r_ptr + IDX'(1);
    // Read is issued at accept, and again only when a non-final beat moves,
    // so a stalled beat keeps the SRAM output (and r_data) stable.
    w_mem_re    = (w_accept && !bus.req.write) || (w_rd_xfer && !w_last_beat);
    w_mem_raddr = (r_state == c_IDLE) ? bus.req.addr[IDX+1:2] : w_ptr_next;
    w_burst     = (int'(bus.req.burst_size) >= MAX_BURST) ? c_BEATS_MAX_M1
                                                           : bus.req.burst_size;
    w_unused_ok = ^{bus.req.cached, bus.req.data_size, bus.req.data_last,
                    bus.req.addr[1:0], bus.req.addr[31:IDX+2]};
  end

  // Drive the response bundle.
  always_comb begin
    bus.resp           = '0;
    bus.resp.ready     = w_ready;
    bus.resp.data_ok   = w_resp_ok;
    bus.resp.data_last = w_resp_ok && w_last_beat;
    bus.resp.r_data    = r_rdata;
  end

  // Transaction FSM: pointer, remaining beats and read-valid tracking.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= c_IDLE;
      r_ptr       <= '0;
      r_beats     <= 4'd0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_accept) begin
            r_ptr   <= bus.req.addr[IDX+1:2];
            r_beats <= w_burst;
            if (bus.req.write) begin
              r_state <= c_WDATA;
            end else begin
              r_state     <= c_RDATA;
              r_out_valid <= 1'b1;
            end
          end
        end
        c_RDATA: begin
          if (w_rd_xfer) begin
            if (w_last_beat) begin
              r_state     <= c_IDLE;
              r_out_valid <= 1'b0;
            end else begin
              r_ptr   <= w_ptr_next;
              r_beats <= r_beats - 4'd1;
            end
          end
        end
        c_WDATA: begin
          if (w_wr_beat) begin
            if (w_last_beat) begin
              r_state <= c_IDLE;
            end else begin
              r_ptr   <= w_ptr_next;
              r_beats <= r_beats - 4'd1;
            end
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  // Single-port SRAM: byte-enabled write of the current beat, registered read.
  always_ff @(posedge clk) begin
    if (w_wr_beat) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.req.data_strobe[b]) begin
          r_mem[r_ptr][b*8 +: 8] <= bus.req.w_data[b*8 +: 8];
        end
      end
    end
    if (w_mem_re) begin
      r_rdata <= r_mem[w_mem_raddr];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cache_bus_sram_slave.sv
//------------------------------------------------------------------------------
// Module      : tb_cache_bus_sram_slave
// Description : Directed self-checking bench for cache_bus_sram_slave.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_cache_bus_sram_slave;

  logic clk;
  logic rst_n;

  cache_bus_sram_slave_if bus ();

  cache_bus_sram_slave #(
    .MEM_WORDS (4096),
    .MAX_BURST (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] wbuf [16];
  logic [31:0] rdat [16];
  logic        rlast [16];
  int          rcyc [16];
  int          nbeats;
  logic        dpat [16];
  int          pat_len;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input int n, input logic [3:0] strb);
    @(negedge clk);
    bus.req.valid      = 1'b1;
    bus.req.write      = 1'b1;
    bus.req.addr       = addr;
    bus.req.burst_size = 4'(n - 1);
    bus.req.data_ok    = 1'b0;
    #1 chk("wr_accept_ready", 32'(bus.resp.ready), 32'd1);
    @(negedge clk);
    bus.req.valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      bus.req.data_ok     = 1'b1;
      bus.req.w_data      = wbuf[i];
      bus.req.data_strobe = strb;
      #1 chk("wr_beat_last", 32'(bus.resp.data_last), 32'(i == n - 1));
      @(negedge clk);
    end
    bus.req.data_ok = 1'b0;
    #1 chk("wr_turnaround_ready", 32'(bus.resp.ready), 32'd1);
  endtask

  task automatic do_read(input logic [31:0] addr, input int n);
    logic        stalled;
    logic [31:0] held;
    int          cyc;
    @(negedge clk);
    bus.req.valid      = 1'b1;
    bus.req.write      = 1'b0;
    bus.req.addr       = addr;
    bus.req.burst_size = 4'(n - 1);
    bus.req.data_ok    = 1'b0;
    #1 chk("rd_accept_ready", 32'(bus.resp.ready), 32'd1);
    @(negedge clk);
    bus.req.valid = 1'b0;
    nbeats  = 0;
    cyc     = 0;
    stalled = 1'b0;
    held    = '0;
    while (nbeats < n && cyc < 64) begin
      bus.req.data_ok = (cyc < pat_len) ? dpat[cyc] : 1'b1;
      #1;
      if (stalled) chk("rd_stall_hold", bus.resp.r_data, held);
      if (bus.resp.data_ok && bus.req.data_ok) begin
        rdat[nbeats]  = bus.resp.r_data;
        rlast[nbeats] = bus.resp.data_last;
        rcyc[nbeats]  = cyc;
        nbeats++;
        stalled = 1'b0;
      end else begin
        stalled = bus.resp.data_ok;
        held    = bus.resp.r_data;
      end
      cyc++;
      @(negedge clk);
    end
    bus.req.data_ok = 1'b0;
    #1;
    chk("rd_beat_count", 32'(nbeats), 32'(n));
    chk("rd_turnaround_ready", 32'(bus.resp.ready), 32'd1);
    chk("rd_turnaround_data_ok", 32'(bus.resp.data_ok), 32'd0);
  endtask

  // Directed sequence covering reset, reads, writes, wrap and mid-burst reset.
  initial begin
    clk     = 1'b0;
    rst_n   = 1'b0;
    bus.req = '0;
    pat_len = 0;

    // Reset outputs
    repeat (3) @(negedge clk);
    #1;
    chk("reset_ready", 32'(bus.resp.ready), 32'd0);
    chk("reset_data_ok", 32'(bus.resp.data_ok), 32'd0);
    chk("reset_data_last", 32'(bus.resp.data_last), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    #1 chk("post_reset_ready", 32'(bus.resp.ready), 32'd1);

    // Preload words 0x100..0x103 and refill them
    for (int i = 0; i < 4; i++) wbuf[i] = 32'hA0A0_0000 + 32'(i);
    do_write(32'h0000_0400, 4, 4'hF);
    do_read(32'h0000_0400, 4);
    for (int i = 0; i < 4; i++) begin
      chk("refill_data", rdat[i], 32'hA0A0_0000 + 32'(i));
      chk("refill_cycle", 32'(rcyc[i]), 32'(i));
      chk("refill_last", 32'(rlast[i]), 32'(i == 3));
    end

    // Uncached single read of word 0x101
    do_read(32'h0000_0404, 1);
    chk("single_data", rdat[0], 32'hA0A0_0001);
    chk("single_last", 32'(rlast[0]), 32'd1);

    // Backpressure 1,0,0,1,1,1
    dpat[0] = 1'b1; dpat[1] = 1'b0; dpat[2] = 1'b0;
    dpat[3] = 1'b1; dpat[4] = 1'b1; dpat[5] = 1'b1;
    pat_len = 6;
    do_read(32'h0000_0400, 4);
    pat_len = 0;
    for (int i = 0; i < 4; i++) begin
      chk("bp_data", rdat[i], 32'hA0A0_0000 + 32'(i));
    end
    chk("bp_first_after_stall_cycle", 32'(rcyc[1]), 32'd3);

    // Strobed write to word 0x10
    wbuf[0] = 32'hFFFF_FFFF;
    do_write(32'h0000_0040, 1, 4'hF);
    wbuf[0] = 32'h1234_5678;
    do_write(32'h0000_0040, 1, 4'b0101);
    do_read(32'h0000_0040, 1);
    chk("strobe_merge", rdat[0], 32'hFF34_FF78);

    // Wrap at the top of the array: words 4094, 4095, 0, 1
    for (int i = 0; i < 4; i++) wbuf[i] = 32'hB0B0_0000 + 32'(i);
    do_write(32'h0000_3FF8, 4, 4'hF);
    do_read(32'h0000_3FF8, 4);
    for (int i = 0; i < 4; i++) begin
      chk("wrap_data", rdat[i], 32'hB0B0_0000 + 32'(i));
    end
    do_read(32'h0000_0000, 1);
    chk("wrap_word0", rdat[0], 32'hB0B0_0002);
    do_read(32'h0001_0004, 1);
    chk("alias_word1", rdat[0], 32'hB0B0_0003);

    // Reset in the middle of a 4-beat write to words 0x200..0x203
    for (int i = 0; i < 4; i++) wbuf[i] = 32'hC0C0_0000 + 32'(i);
    do_write(32'h0000_0800, 4, 4'hF);
    @(negedge clk);
    bus.req.valid      = 1'b1;
    bus.req.write      = 1'b1;
    bus.req.addr       = 32'h0000_0800;
    bus.req.burst_size = 4'd3;
    @(negedge clk);
    bus.req.valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.req.data_ok     = 1'b1;
      bus.req.w_data      = 32'hD0D0_0000 + 32'(i);
      bus.req.data_strobe = 4'hF;
      @(negedge clk);
    end
    bus.req.data_ok = 1'b1;
    bus.req.w_data  = 32'hD0D0_0002;
    rst_n           = 1'b0;
    #1;
    chk("midrst_data_ok", 32'(bus.resp.data_ok), 32'd0);
    chk("midrst_ready", 32'(bus.resp.ready), 32'd0);
    @(negedge clk);
    bus.req.data_ok = 1'b0;
    #1 chk("midrst_data_ok_hold", 32'(bus.resp.data_ok), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("midrst_release_ready", 32'(bus.resp.ready), 32'd1);
    chk("midrst_release_data_ok", 32'(bus.resp.data_ok), 32'd0);
    do_read(32'h0000_0800, 4);
    chk("midrst_word0", rdat[0], 32'hD0D0_0000);
    chk("midrst_word1", rdat[1], 32'hD0D0_0001);
    chk("midrst_word2", rdat[2], 32'hC0C0_0002);
    chk("midrst_word3", rdat[3], 32'hC0C0_0003);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
